// File: rtl/onchip_arb_pkg.sv
// Shared types and defaults for the on-chip RAM arbiter.
// Optional statistics counters are built when ONCHIP_ARB_STATS_EN is defined.
package onchip_arb_pkg;

    localparam int ARB_ADDR_W = 15;
    localparam int ARB_DATA_W = 32;
    localparam int STAT_W     = 32;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } mst_e;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM bundle: two master ports plus the RAM-side port.
// The arbiter uses the slave modport; masters and the RAM use master.
interface onchip_mem_arbiter_if
    import onchip_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
);
    logic [ADDR_W-1:0]   m0_address;
    logic [DATA_W/8-1:0] m0_byteenable;
    logic                m0_read;
    logic                m0_write;
    logic [DATA_W-1:0]   m0_writedata;
    logic                m0_waitrequest;
    logic [DATA_W-1:0]   m0_readdata;
    logic                m0_readdatavalid;

    logic [ADDR_W-1:0]   m1_address;
    logic [DATA_W/8-1:0] m1_byteenable;
    logic                m1_read;
    logic                m1_write;
    logic [DATA_W-1:0]   m1_writedata;
    logic                m1_waitrequest;
    logic [DATA_W-1:0]   m1_readdata;
    logic                m1_readdatavalid;

    logic [ADDR_W-1:0]   mem_address;
    logic [DATA_W/8-1:0] mem_byteenable;
    logic                mem_chipselect;
    logic                mem_write;
    logic [DATA_W-1:0]   mem_writedata;
    logic                mem_clken;
    logic [DATA_W-1:0]   mem_readdata;

    modport slave (
        input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write,
        output mem_writedata, mem_clken,
        input  mem_readdata
    );

    modport master (
        output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write,
        input  mem_writedata, mem_clken,
        output mem_readdata
    );

endinterface

// File: rtl/onchip_mem_arbiter_rr_arbiter2.sv
// Two-input grant logic: round-robin or fixed m0 priority.
// No grant is issued while reset_n is low.
module rr_arbiter2
    import onchip_arb_pkg::*;
#(
    parameter int M0_PRIORITY = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    mst_e last_d, last_q;
    logic m0_wins;

    assign m0_wins = (M0_PRIORITY != 0) ? 1'b1 : (last_q == M1);

    assign gnt0_o = reset_n & req0_i & (~req1_i | m0_wins);
    assign gnt1_o = reset_n & req1_i & (~req0_i | ~m0_wins);

    // Any grant is an accepted transfer, so ownership moves with it.
    always_comb begin
        last_d = last_q;
        unique case (1'b1)
            gnt0_o:  last_d = M0;
            gnt1_o:  last_d = M1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q <= M1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port RAM between two Avalon-MM masters.
// Define ONCHIP_ARB_STATS_EN to add conflict/transfer counters.
module onchip_mem_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int ADDR_W      = ARB_ADDR_W,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int M0_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              reset_n,
`ifdef ONCHIP_ARB_STATS_EN
    input  logic              stat_clear,
    output logic [STAT_W-1:0] stat_conflicts,
    output logic [STAT_W-1:0] stat_m0_xfers,
    output logic [STAT_W-1:0] stat_m1_xfers,
`endif
    onchip_mem_arbiter_if.slave bus
);

    localparam int BE_W = DATA_W / 8;

    logic req0, req1, gnt0, gnt1;
    logic wr, rd_acc;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [BE_W-1:0]   be_d, be_q;
    logic [DATA_W-1:0] wd_d, wd_q;
    logic rd_pend_d, rd_pend_q;
    mst_e rd_tag_d, rd_tag_q;

    assign req0 = bus.m0_read | bus.m0_write;
    assign req1 = bus.m1_read | bus.m1_write;

    rr_arbiter2 #(
        .M0_PRIORITY(M0_PRIORITY)
    ) u_arb (
        .clk    (clk),
        .reset_n(reset_n),
        .req0_i (req0),
        .req1_i (req1),
        .gnt0_o (gnt0),
        .gnt1_o (gnt1)
    );

    assign bus.m0_waitrequest = req0 & ~gnt0;
    assign bus.m1_waitrequest = req1 & ~gnt1;

    // Idle cycles keep the last address/data on the RAM pins.
    always_comb begin
        addr_d   = addr_q;
        be_d     = be_q;
        wd_d     = wd_q;
        wr       = 1'b0;
        rd_acc   = 1'b0;
        rd_tag_d = rd_tag_q;
        unique case (1'b1)
            gnt0: begin
                addr_d   = bus.m0_address;
                be_d     = bus.m0_byteenable;
                wd_d     = bus.m0_writedata;
                wr       = bus.m0_write;
                rd_acc   = bus.m0_read & ~bus.m0_write;
                rd_tag_d = M0;
            end
            gnt1: begin
                addr_d   = bus.m1_address;
                be_d     = bus.m1_byteenable;
                wd_d     = bus.m1_writedata;
                wr       = bus.m1_write;
                rd_acc   = bus.m1_read & ~bus.m1_write;
                rd_tag_d = M1;
            end
            default: ;
        endcase
    end

    assign rd_pend_d = rd_acc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q    <= '0;
            be_q      <= '0;
            wd_q      <= '0;
            rd_pend_q <= 1'b0;
            rd_tag_q  <= M0;
        end else begin
            addr_q    <= addr_d;
            be_q      <= be_d;
            wd_q      <= wd_d;
            rd_pend_q <= rd_pend_d;
            rd_tag_q  <= rd_tag_d;
        end
    end

    assign bus.mem_address    = addr_d;
    assign bus.mem_byteenable = be_d;
    assign bus.mem_writedata  = wd_d;
    assign bus.mem_write      = wr;
    assign bus.mem_chipselect = gnt0 | gnt1;
    assign bus.mem_clken      = 1'b1;

    assign bus.m0_readdata = bus.mem_readdata;
    assign bus.m1_readdata = bus.mem_readdata;
    assign bus.m0_readdatavalid = reset_n & rd_pend_q & (rd_tag_q == M0);
    assign bus.m1_readdatavalid = reset_n & rd_pend_q & (rd_tag_q == M1);

`ifdef ONCHIP_ARB_STATS_EN
    logic [STAT_W-1:0] conf_q, x0_q, x1_q;

    always_ff @(posedge clk) begin
        if (!reset_n || stat_clear) begin
            conf_q <= '0;
            x0_q   <= '0;
            x1_q   <= '0;
        end else begin
            if (req0 & req1) conf_q <= sat_inc(conf_q);
            if (gnt0)        x0_q   <= sat_inc(x0_q);
            if (gnt1)        x1_q   <= sat_inc(x1_q);
        end
    end

    assign stat_conflicts = conf_q;
    assign stat_m0_xfers  = x0_q;
    assign stat_m1_xfers  = x1_q;
`endif

endmodule
